// File: rtl/sram_stream_pkg.sv
// Shared types and default sizes for the sram read streamer.
package sram_stream_pkg;

  localparam int RS_ADDR_W     = 12;
  localparam int RS_DATA_W     = 16;
  localparam int RS_LEN_W      = 12;
  localparam int RS_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rs_state_e;

  // One buffered output beat: data word plus end-of-transfer marker.
  typedef struct packed {
    logic                 last;
    logic [RS_DATA_W-1:0] data;
  } rs_beat_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO for read data; push and pop may coincide when full or empty.
module sram_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state: pop only real data; a push into a full FIFO is fine if a pop frees a slot.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low flush.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sram_read_streamer.sv
// Walks LENGTH sram words from BASE, respecting read latency, write hazards and
// output-buffer credit, and streams them out over valid/ready.
module sram_read_streamer
  import sram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = RS_ADDR_W,
  parameter int DATA_WIDTH = RS_DATA_W,
  parameter int LEN_WIDTH  = RS_LEN_W,
  parameter int FIFO_DEPTH = RS_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_x_o,
  output logic [ADDR_WIDTH-1:0] sram_read_address_o,
  input  logic [DATA_WIDTH-1:0] sram_read_data_i,
  input  logic                  snoop_we_i,
  input  logic [ADDR_WIDTH-1:0] snoop_waddr_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rs_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  pending_q, pending_d;
  logic                  pending_last_q, pending_last_d;
  logic                  last_we_q, last_we_d;
  logic [ADDR_WIDTH-1:0] last_waddr_q, last_waddr_d;
  logic                  err_x_q, err_x_d;

  logic [DATA_WIDTH:0]   fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  pop, credit_ok, hazard, issue, x_seen;
  logic [CW:0]           occupancy;

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (pending_q),
    .push_data_i ({pending_last_q, sram_read_data_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign m_valid_o           = !fifo_empty;
  assign m_data_o            = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign m_last_o            = !fifo_empty && fifo_head[DATA_WIDTH];
  assign busy_o              = (state_q != IDLE);
  assign done_o              = (state_q == DONE);
  assign err_x_o             = err_x_q;
  assign sram_read_address_o = addr_q;

  // Issue gating: a read needs a guaranteed FIFO slot and no write racing its address
  // in this cycle or the previous one (the sram may not reflect that write yet).
  always_comb begin
    pop       = m_valid_o && m_ready_i;
    occupancy = {1'b0, fifo_count} + (CW+1)'(pending_q) - (CW+1)'(pop);
    credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
    hazard    = (snoop_we_i && (snoop_waddr_i == addr_q)) ||
                (last_we_q  && (last_waddr_q  == addr_q));
    issue     = (state_q == RUN) && credit_ok && !hazard;
    x_seen    = pending_q && ((^sram_read_data_i) === 1'bx);
  end

  // Transfer sequencing, address walk and in-flight read tracking.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remain_d       = remain_q;
    pending_d      = issue;
    pending_last_d = issue && (remain_q == LEN_WIDTH'(1));
    last_we_d      = snoop_we_i;
    last_waddr_d   = snoop_waddr_i;
    err_x_d        = err_x_q || x_seen;
    if (issue) begin
      addr_d   = addr_q + ADDR_WIDTH'(1);
      remain_d = remain_q - LEN_WIDTH'(1);
    end
    case (state_q)
      IDLE: if (start_i) begin
        addr_d   = base_addr_i;
        remain_d = length_i;
        state_d  = (length_i == '0) ? DONE : RUN;
      end
      RUN:   if (issue && (remain_q == LEN_WIDTH'(1))) state_d = DRAIN;
      // Leave on the edge that takes the last beat so done_o follows it directly.
      DRAIN: if (!pending_q && (fifo_empty || ((fifo_count == CW'(1)) && pop))) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register update; reset aborts any transfer silently.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remain_q       <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      last_we_q      <= 1'b0;
      last_waddr_q   <= '0;
      err_x_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remain_q       <= remain_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      last_we_q      <= last_we_d;
      last_waddr_q   <= last_waddr_d;
      err_x_q        <= err_x_d;
    end
  end

endmodule

// File: tb/tb_sram_read_streamer.sv
// Scoreboard bench: driver queues expected beats from a plain memory model, monitor
// pops and compares on every handshake.
module tb_sram_read_streamer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [11:0] base_addr_i = '0;
  logic [11:0] length_i = '0;
  logic        busy_o, done_o, err_x_o;
  logic [11:0] sram_read_address_o;
  logic [15:0] sram_read_data_i;
  logic        snoop_we_i = 1'b0;
  logic [11:0] snoop_waddr_i = '0;
  logic [15:0] sram_wdata = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [15:0] m_data_o;
  logic        m_last_o;

  sram_read_streamer dut (
    .clock               (clock),
    .reset               (reset),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .length_i            (length_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .err_x_o             (err_x_o),
    .sram_read_address_o (sram_read_address_o),
    .sram_read_data_i    (sram_read_data_i),
    .snoop_we_i          (snoop_we_i),
    .snoop_waddr_i       (snoop_waddr_i),
    .m_valid_o           (m_valid_o),
    .m_ready_i           (m_ready_i),
    .m_data_o            (m_data_o),
    .m_last_o            (m_last_o)
  );

  always #5 clock = ~clock;

  int npass = 0, ntotal = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 40503 + 32'h1357);
  endfunction

  // sram model: 1-cycle registered read, preloaded on the first clock.
  logic [15:0] sram_mem [4096];
  logic        sram_loaded = 1'b0;
  logic [15:0] sram_rd = '0;
  assign sram_read_data_i = sram_rd;
  always @(posedge clock) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= pat(i);
      sram_loaded <= 1'b1;
    end else if (snoop_we_i) sram_mem[snoop_waddr_i] <= sram_wdata;
    sram_rd <= sram_mem[sram_read_address_o];
  end

  // Reference memory contents as the consumer should see them.
  logic [15:0] ref_mem [4096];
  logic [16:0] exp_q [$];
  logic [11:0] cur_base = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  int rmode = 0, rph = 0;
  always @(posedge clock) begin
    #1;
    case (rmode)
      1:       m_ready_i = ((rph % 4) == 0) || ((rph % 4) == 3);
      2:       m_ready_i = 1'($urandom % 2);
      default: m_ready_i = 1'b1;
    endcase
    rph++;
  end

  // Monitor: scoreboard pop, stability under backpressure, outstanding-read bound.
  int xfer_beats = 0, first_beat_cyc = -1, last_beat_cyc = -1, beats_total = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clock) begin
    if (!reset) begin
      xfer_beats = 0;
      prev_stall = 0;
    end else begin
      if (!busy_o) xfer_beats = 0;
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid_o), 32'd1);
        chk("hold_data", 32'(m_data_o), 32'(prev_data));
        chk("hold_last", 32'(m_last_o), 32'(prev_last));
      end
      if (busy_o) begin
        logic [11:0] issued;
        issued = sram_read_address_o - cur_base;
        chk("in_flight_le_2", 32'((int'(issued) - xfer_beats) <= 2), 32'd1);
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(m_data_o), 32'hDEAD_0000);
        else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_data_o), 32'(e[15:0]));
          chk("beat_last", 32'(m_last_o), 32'(e[16]));
        end
        if (xfer_beats == 0) first_beat_cyc = cyc;
        if (m_last_o) last_beat_cyc = cyc;
        xfer_beats++;
        beats_total++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  task automatic push_xfer(input int base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), ref_mem[(base + i) % 4096]});
  endtask

  // Called at posedge+1; returns the cycle stamp of the edge that accepted the start.
  task automatic do_start(input int base, input int len, output int sc);
    cur_base    = 12'(base);
    base_addr_i = 12'(base);
    length_i    = 12'(len);
    start_i     = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    sc      = cyc;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int k = 0; k < 400; k++) begin
      if (done_o) begin
        dc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_xfer(input string nm, input int base, input int len);
    int sc, dc;
    push_xfer(base, len);
    do_start(base, len, sc);
    wait_done(dc);
    chk({nm, "_done_after_last"}, 32'(dc), 32'(last_beat_cyc + 1));
    @(posedge clock); #1;
    chk({nm, "_idle"}, 32'(busy_o), 32'd0);
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"}, 32'(busy_o), 32'd0);
    chk({nm, "_done"}, 32'(done_o), 32'd0);
    chk({nm, "_err"}, 32'(err_x_o), 32'd0);
    chk({nm, "_valid"}, 32'(m_valid_o), 32'd0);
    chk({nm, "_last"}, 32'(m_last_o), 32'd0);
    chk({nm, "_data"}, 32'(m_data_o), 32'd0);
    chk({nm, "_addr"}, 32'(sram_read_address_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc, dc, cnt, bt, b, l;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clock);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic transfer with latency check.
    push_xfer(12'h010, 4);
    do_start(12'h010, 4, sc);
    wait_done(dc);
    chk("t1_first_beat_latency", 32'(first_beat_cyc), 32'(sc + 2));
    chk("t1_done_after_last", 32'(dc), 32'(last_beat_cyc + 1));
    chk("t1_last_beat_span", 32'(last_beat_cyc), 32'(sc + 5));
    @(posedge clock); #1;
    chk("t1_err_x", 32'(err_x_o), 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the sram.
    run_xfer("wrap", 12'hFFE, 4);

    // Backpressure pattern.
    rmode = 1;
    run_xfer("bp", 12'h200, 8);
    rmode = 0;
    @(posedge clock); #1;

    // Write hazard on 0x012 in the cycle its read is due.
    ref_mem[12'h012] = 16'hBEEF;
    push_xfer(12'h010, 4);
    do_start(12'h010, 4, sc);
    for (int k = 0; k < 20 && sram_read_address_o != 12'h012; k++) begin
      @(posedge clock); #1;
    end
    snoop_we_i    = 1'b1;
    snoop_waddr_i = 12'h012;
    sram_wdata    = 16'hBEEF;
    cnt = 1;
    @(posedge clock); #1;
    snoop_we_i = 1'b0;
    while (sram_read_address_o == 12'h012 && cnt < 10) begin
      cnt++;
      @(posedge clock); #1;
    end
    chk("hazard_addr_held_cycles", 32'(cnt), 32'd3);
    wait_done(dc);
    chk("hazard_done_after_last", 32'(dc), 32'(last_beat_cyc + 1));
    @(posedge clock); #1;
    chk("hazard_err_x", 32'(err_x_o), 32'd0);
    chk("hazard_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length transfer.
    bt = beats_total;
    do_start(12'h345, 0, sc);
    wait_done(dc);
    chk("len0_done_cycle", 32'(dc), 32'(sc));
    chk("len0_addr_unchanged", 32'(sram_read_address_o), 32'h345);
    @(posedge clock); #1;
    chk("len0_idle", 32'(busy_o), 32'd0);
    chk("len0_no_beats", 32'(beats_total), 32'(bt));

    // Start while busy must be ignored.
    push_xfer(12'h100, 4);
    do_start(12'h100, 4, sc);
    @(posedge clock); #1;
    base_addr_i = 12'h200;
    length_i    = 12'd3;
    start_i     = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    wait_done(dc);
    chk("busy_start_done_after_last", 32'(dc), 32'(last_beat_cyc + 1));
    chk("busy_start_end_addr", 32'(sram_read_address_o), 32'h104);
    repeat (5) @(posedge clock);
    #1;
    chk("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_start_idle", 32'(busy_o), 32'd0);

    // Reset mid-transfer after beat 2 of 6.
    push_xfer(12'h040, 6);
    do_start(12'h040, 6, sc);
    for (int k = 0; k < 50 && xfer_beats < 2; k++) begin
      @(posedge clock); #1;
    end
    chk("midreset_reached_beat2", 32'(xfer_beats), 32'd2);
    reset = 1'b0;
    @(posedge clock); #1;
    chk_zero_outputs("midreset");
    exp_q.delete();
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midreset_no_done", 32'(done_o), 32'd0);
    run_xfer("after_reset", 12'h080, 2);

    // Randomized transfers.
    for (int it = 0; it < 8; it++) begin
      b     = int'($urandom % 4096);
      l     = 1 + int'($urandom % 12);
      rmode = int'($urandom % 3);
      run_xfer("rand", b, l);
    end
    rmode = 0;
    @(posedge clock); #1;
    chk("final_err_x", 32'(err_x_o), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
